// File: rtl/mc_adder.sv
// mc_adder: multi-cycle adder/subtractor summing CHUNK bits per cycle through a ripple chain
module mc_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] ca, cb, s;
  logic [CHUNK:0] cy;
  logic last;
  assign ca = a_q[k_q];
  assign cb = b_q[k_q];
  assign cy[0] = c_q;
  assign last = k_q == KW'(NCHUNK - 1);
  for (genvar i = 0; i < CHUNK; i++) begin : fadd
    assign s[i] = ca[i] ^ cb[i] ^ cy[i];
    assign cy[i+1] = (ca[i] & cb[i]) | (cy[i] & (ca[i] ^ cb[i]));
  end
  assign ready = state_q == IDLE;
  assign done = state_q == DONE;
  assign r = r_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  // next state: capture operands on accepted start, add one chunk per RUN cycle
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    k_d = k_q;
    c_d = c_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d = a;
        b_d = sub ? ~b : b;
        c_d = sub ? 1'b1 : cin;
        r_d = '0;
        k_d = '0;
        cout_d = 1'b0;
        ovf_d = 1'b0;
      end
      RUN: begin
        r_d[k_q] = s;
        c_d = cy[CHUNK];
        k_d = last ? '0 : k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cout_d = cy[CHUNK];
          ovf_d = cy[CHUNK] ^ cy[CHUNK-1];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      k_q <= '0;
      c_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      k_q <= k_d;
      c_q <= c_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mc_adder.sv
// tb_mc_adder: scoreboard bench for mc_adder, directed cases on 16/4 plus random sweeps on other shapes
module tb_mc_adder;
  typedef struct {
    longint r;
    bit c;
    bit o;
    longint t0;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fin = 0;
  logic rst0 = 0;
  logic rst_s = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(input int w, input longint x, input longint y, input bit s, input bit c,
                                 input longint t0);
    exp_t e;
    longint m, us, sx, sy, ss;
    m = longint'(1) << w;
    us = s ? x - y : x + y + longint'(c);
    sx = x >= m / 2 ? x - m : x;
    sy = y >= m / 2 ? y - m : y;
    ss = s ? sx - sy : sx + sy + longint'(c);
    e.r = us & (m - 1);
    e.c = s ? (x >= y) : (us >= m);
    e.o = (ss < -(m / 2)) || (ss >= m / 2);
    e.t0 = t0;
    return e;
  endfunction

  logic start0 = 0, sub0 = 0, cin0 = 0;
  logic [15:0] a0 = '0, b0 = '0;
  logic ready0, done0, cout0, ovf0;
  logic [15:0] r0;

  mc_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .sub(sub0), .cin(cin0), .a(a0), .b(b0),
    .ready(ready0), .done(done0), .r(r0), .cout(cout0), .ovf(ovf0)
  );

  exp_t q0[$];
  exp_t last0;
  bit have0 = 0;

  always @(negedge clk) begin
    if (rst0) have0 = 0;
    else if (done0) begin
      check("u0 done has pending op", longint'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        last0 = q0.pop_front();
        check("u0 r", r0, last0.r);
        check("u0 cout", cout0, last0.c);
        check("u0 ovf", ovf0, last0.o);
        check("u0 latency", cyc + 1 - last0.t0, 5);
        have0 = 1;
      end
    end else if (ready0 && have0) begin
      check("u0 hold r", r0, last0.r);
      check("u0 hold cout", cout0, last0.c);
      check("u0 hold ovf", ovf0, last0.o);
    end
  end

  task automatic wait_ready0();
    int n = 0;
    while (!ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready0) check("u0 ready wait", ready0, 1);
  endtask

  task automatic go0(input logic [15:0] x, input logic [15:0] y, input bit s, input bit c, input bit push);
    wait_ready0();
    a0 = x; b0 = y; sub0 = s; cin0 = c; start0 = 1;
    if (push) q0.push_back(model(16, longint'(x), longint'(y), s, c, cyc + 1));
    @(negedge clk);
    start0 = 0;
    check("u0 r cleared on start", r0, 0);
    check("u0 cout cleared on start", cout0, 0);
    check("u0 ovf cleared on start", ovf0, 0);
    a0 = 16'($urandom); b0 = 16'($urandom); sub0 = 1'($urandom); cin0 = 1'($urandom);
  endtask

  task automatic b2b0(input logic [15:0] x1, input logic [15:0] y1, input bit s1, input bit c1,
                      input logic [15:0] x2, input logic [15:0] y2, input bit s2, input bit c2);
    int n = 0;
    longint t;
    wait_ready0();
    t = cyc + 1;
    a0 = x1; b0 = y1; sub0 = s1; cin0 = c1; start0 = 1;
    q0.push_back(model(16, longint'(x1), longint'(y1), s1, c1, t));
    q0.push_back(model(16, longint'(x2), longint'(y2), s2, c2, t + 6));
    @(negedge clk);
    a0 = x2; b0 = y2; sub0 = s2; cin0 = c2;
    do begin
      @(negedge clk);
      n++;
    end while (!ready0 && n < 100);
    if (!ready0) check("u0 b2b ready wait", ready0, 1);
    @(negedge clk);
    start0 = 0;
  endtask

  initial begin
    int n;
    #1;
    rst0 = 1;
    rst_s = 1;
    #1;
    check("reset ready", ready0, 1);
    check("reset done", done0, 0);
    check("reset r", r0, 0);
    check("reset cout", cout0, 0);
    check("reset ovf", ovf0, 0);
    repeat (2) @(negedge clk);
    rst0 = 0;
    rst_s = 0;
    go0(16'hFFFF, 16'h0001, 0, 0, 1);
    go0(16'h7FFF, 16'h0001, 0, 0, 1);
    go0(16'h1234, 16'h1111, 0, 1, 1);
    go0(16'h0005, 16'h0007, 1, 0, 1);
    go0(16'h8000, 16'h0001, 1, 0, 1);
    go0(16'h00AA, 16'h0F0F, 0, 1, 1);
    @(negedge clk);
    a0 = 16'h1111; b0 = 16'h2222; start0 = 1;
    @(negedge clk);
    start0 = 0;
    b2b0(16'hFFF0, 16'h0010, 0, 1, 16'h0000, 16'h0001, 1, 1);
    go0(16'h3333, 16'h4444, 0, 0, 0);
    @(posedge clk);
    #2;
    rst0 = 1;
    #1;
    check("abort ready", ready0, 1);
    check("abort done", done0, 0);
    check("abort r", r0, 0);
    check("abort cout", cout0, 0);
    check("abort ovf", ovf0, 0);
    @(negedge clk);
    #3;
    rst0 = 0;
    go0(16'hABCD, 16'h1357, 1, 1, 1);
    repeat (200) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      go0($urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom),
          $urandom_range(0, 3) == 0 ? 16'h8000 : 16'($urandom), 1'($urandom), 1'($urandom), 1);
    end
    n = 0;
    while ((n_fin < 3 || q0.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("u0 ops outstanding", q0.size(), 0);
    check("sweep blocks finished", n_fin, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  for (genvar i = 0; i < 3; i++) begin : g
    localparam int W = i == 0 ? 8 : i == 1 ? 16 : 32;
    localparam int C = i == 0 ? 1 : i == 1 ? 16 : 8;
    localparam int N = W / C;
    logic start = 0, sub = 0, cin = 0;
    logic [W-1:0] a = '0, b = '0;
    logic ready, done, cout, ovf;
    logic [W-1:0] r;
    exp_t q[$];
    exp_t last;
    bit have = 0;

    mc_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst_s), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .ready(ready), .done(done), .r(r), .cout(cout), .ovf(ovf)
    );

    always @(negedge clk) begin
      if (rst_s) have = 0;
      else if (done) begin
        check($sformatf("w%0d_c%0d done has pending op", W, C), longint'(q.size() != 0), 1);
        if (q.size() != 0) begin
          last = q.pop_front();
          check($sformatf("w%0d_c%0d r", W, C), r, last.r);
          check($sformatf("w%0d_c%0d cout", W, C), cout, last.c);
          check($sformatf("w%0d_c%0d ovf", W, C), ovf, last.o);
          check($sformatf("w%0d_c%0d latency", W, C), cyc + 1 - last.t0, N + 1);
          have = 1;
        end
      end else if (ready && have) begin
        check($sformatf("w%0d_c%0d hold r", W, C), r, last.r);
      end
    end

    initial begin
      int n;
      @(negedge rst_s);
      repeat (1000) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        n = 0;
        while (!ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!ready) check($sformatf("w%0d_c%0d ready wait", W, C), ready, 1);
        a = $urandom_range(0, 3) == 0 ? {W{1'b1}} : W'($urandom);
        b = $urandom_range(0, 3) == 0 ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
        start = 1;
        q.push_back(model(W, longint'(a), longint'(b), sub, cin, cyc + 1));
        @(negedge clk);
        start = 0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("w%0d_c%0d ops outstanding", W, C), q.size(), 0);
      n_fin++;
    end
  end
endmodule
